// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Operands are latched at issue; the result is formed from them at the last busy cycle.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    op_e              op_q;

    logic [63:0] prod;
    logic        div_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_we;

    // Signed division works on magnitudes, then restores signs: quotient truncates
    // toward zero and the remainder follows the dividend. 0x80000000 / -1 falls out
    // naturally as LO=0x80000000, HI=0.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        prod   = '0;
        uq     = '0;
        ur     = '0;
        res_hi = HI;
        res_lo = LO;
        res_we = 1'b0;

        div_signed = (op_q == OP_DIV);
        a_mag      = (div_signed && a_q[31]) ? -a_q : a_q;
        b_mag      = (div_signed && b_q[31]) ? -b_q : b_q;
        if (b_q != 32'd0) begin
            uq = a_mag / b_mag;
            ur = a_mag % b_mag;
        end
        quot = (div_signed && (a_q[31] ^ b_q[31])) ? -uq : uq;
        rem  = (div_signed && a_q[31]) ? -ur : ur;

        case (op_q)
            OP_MULT: begin
                prod   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
                res_we = 1'b1;
            end
            OP_MULTU: begin
                prod   = {32'd0, a_q} * {32'd0, b_q};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
                res_we = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_hi = rem;
                res_lo = quot;
                res_we = (b_q != 32'd0);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_MULT;
            HI    <= '0;
            LO    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op_e'(op))
                            OP_MULT, OP_MULTU: begin
                                a_q   <= A;
                                b_q   <= B;
                                op_q  <= op_e'(op);
                                cnt   <= CNT_W'(MULT_CYCLES);
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                a_q   <= A;
                                b_q   <= B;
                                op_q  <= op_e'(op);
                                cnt   <= CNT_W'(DIV_CYCLES);
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here; stall logic owns that.
                    if (cnt == CNT_W'(1)) begin
                        if (res_we) begin
                            HI <= res_hi;
                            LO <= res_lo;
                        end
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: hand-computed HI/LO results and busy-window lengths.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives one issue cycle and returns at the next negedge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd6;
    endtask

    // Counts negedges with busy high (including the current one), bounded.
    task automatic wait_done(input string tag, input int exp_cycles);
        int n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        check({tag, "_HI"}, HI, hi);
        check({tag, "_LO"}, LO, lo);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd6;
        A     = '0;
        B     = '0;
        @(negedge clk);
        do_reset();
        check("reset_busy", 32'(busy), 32'd0);
        check_hilo("reset", 32'd0, 32'd0);

        // Idle for 20 cycles with start low
        for (int i = 0; i < 20; i++) begin
            A = 32'h1234_0000 + 32'(i);
            B = 32'hFFFF_0000 - 32'(i);
            op = 3'(i);
            @(negedge clk);
        end
        check("idle_busy", 32'(busy), 32'd0);
        check_hilo("idle", 32'd0, 32'd0);

        // MULT -3 * 5
        issue(3'd0, 32'hFFFF_FFFD, 32'd5);
        wait_done("mult", 5);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // MULTU issued the first cycle busy reads 0
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu", 5);
        check_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        // DIV -7 / 2
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_hi_held", HI, 32'hFFFF_FFFE);
        wait_done("div", 10);
        check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(3'd3, 32'd7, 32'd2);
        wait_done("divu", 10);
        check_hilo("divu", 32'd1, 32'd3);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 10);
        check_hilo("div_ovf", 32'd0, 32'h8000_0000);

        // Signed DIV with negative divisor: 7 / -2 = -3 rem 1
        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_negb", 10);
        check_hilo("div_negb", 32'd1, 32'hFFFF_FFFD);

        // MTHI / MTLO then divide by zero
        issue(3'd4, 32'h1111_1111, 32'd0);
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_HI", HI, 32'h1111_1111);
        issue(3'd5, 32'h2222_2222, 32'd0);
        check("mtlo_busy", 32'(busy), 32'd0);
        check("mtlo_LO", LO, 32'h2222_2222);
        issue(3'd3, 32'd7, 32'd0);
        wait_done("divz", 10);
        check_hilo("divz", 32'h1111_1111, 32'h2222_2222);

        // No-op opcodes leave everything alone
        issue(3'd7, 32'hAAAA_AAAA, 32'd1);
        check("nop_busy", 32'(busy), 32'd0);
        check_hilo("nop", 32'h1111_1111, 32'h2222_2222);

        // Start while busy is ignored; operand changes mid-run are ignored
        do_reset();
        issue(3'd0, 32'd6, 32'd7);
        @(negedge clk);
        start = 1'b1;
        op    = 3'd2;
        A     = 32'd100;
        B     = 32'd9;
        @(negedge clk);
        op    = 3'd5;
        A     = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd6;
        A     = 32'd1000;
        B     = 32'd1000;
        check("ignored_busy", 32'(busy), 32'd1);
        wait_done("ignored_tail", 2);
        check_hilo("ignored", 32'd0, 32'd42);

        // Reset in the middle of a DIV
        issue(3'd2, 32'd100, 32'd3);
        repeat (3) @(negedge clk);
        do_reset();
        check("midreset_busy", 32'(busy), 32'd0);
        check_hilo("midreset", 32'd0, 32'd0);
        repeat (12) @(negedge clk);
        check("midreset_late_busy", 32'(busy), 32'd0);
        check_hilo("midreset_late", 32'd0, 32'd0);
        issue(3'd0, 32'd2, 32'd3);
        wait_done("post_reset_mult", 5);
        check_hilo("post_reset_mult", 32'd0, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
